// File: rtl/mem_stage_controller.sv
// rtl/mem_stage_controller.sv - MEM-stage load/store sequencer with pipeline stall (optional MEM_TIMEOUT_EN abort)
module mem_stage_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAluResult,
    input  logic [31:0] memMemoryWriteData,
    input  logic        memMemRead,
    input  logic        memMemWrite,
    output logic        stall,
    output logic        dmemReqValid,
    output logic        dmemReqWrite,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    input  logic        dmemReqReady,
    input  logic        dmemRespValid,
    input  logic [31:0] dmemRData,
    output logic [31:0] memReadData,
    output logic        memAccessError
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t state;
    state_t state_next;
    logic   access;
    logic   handshake;
    logic   abort;
    logic   unused_addr_lsb;

    assign access          = memMemRead | memMemWrite;
    assign handshake       = dmemReqValid & dmemReqReady;
    assign unused_addr_lsb = ^memAluResult[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_cnt;

    // A handshake or response landing on the last allowed cycle still wins.
    always_comb begin
        abort = 1'b0;
        if (timeout_cnt == TIMEOUT_LAST) begin
            if (state == REQ)
                abort = !handshake;
            else if (state == RESP)
                abort = !dmemRespValid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt    <= 8'd0;
            memAccessError <= 1'b0;
        end else begin
            memAccessError <= abort;
            if (state == IDLE && access)
                timeout_cnt <= 8'd0;
            else if (state == REQ || state == RESP)
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`else
    logic unused_cfg;

    assign abort          = 1'b0;
    assign memAccessError = 1'b0;
    assign unused_cfg     = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access) state_next = REQ;
            REQ: begin
                if (handshake)
                    state_next = dmemReqWrite ? DONE : RESP;
                else if (abort)
                    state_next = DONE;
            end
            RESP: if (dmemRespValid || abort) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall depends only on state and strobes so the barriers never see memory-side timing.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access;
            REQ:     stall = 1'b1;
            RESP:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmemReqValid <= 1'b0;
            dmemReqWrite <= 1'b0;
            dmemAddr     <= 32'd0;
            dmemWData    <= 32'd0;
            memReadData  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        dmemReqValid <= 1'b1;
                        dmemReqWrite <= memMemWrite;
                        dmemAddr     <= {memAluResult[31:2], 2'b00};
                        dmemWData    <= memMemoryWriteData;
                    end
                end
                REQ: begin
                    if (handshake || abort)
                        dmemReqValid <= 1'b0;
                    if (!handshake && abort && !dmemReqWrite)
                        memReadData <= 32'hDEADBEEF;
                end
                RESP: begin
                    if (dmemRespValid)
                        memReadData <= dmemRData;
                    else if (abort)
                        memReadData <= 32'hDEADBEEF;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_controller.sv
// tb/tb_mem_stage_controller.sv - scoreboard bench for mem_stage_controller (MEM_TIMEOUT_EN selects abort scenario)
module tb_mem_stage_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memAluResult = '0;
    logic [31:0] memMemoryWriteData = '0;
    logic        memMemRead = 1'b0;
    logic        memMemWrite = 1'b0;
    logic        stall;
    logic        dmemReqValid;
    logic        dmemReqWrite;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWData;
    logic        dmemReqReady = 1'b0;
    logic        dmemRespValid = 1'b0;
    logic [31:0] dmemRData = '0;
    logic [31:0] memReadData;
    logic        memAccessError;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [64:0] req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_stage_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .memAluResult       (memAluResult),
        .memMemoryWriteData (memMemoryWriteData),
        .memMemRead         (memMemRead),
        .memMemWrite        (memMemWrite),
        .stall              (stall),
        .dmemReqValid       (dmemReqValid),
        .dmemReqWrite       (dmemReqWrite),
        .dmemAddr           (dmemAddr),
        .dmemWData          (dmemWData),
        .dmemReqReady       (dmemReqReady),
        .dmemRespValid      (dmemRespValid),
        .dmemRData          (dmemRData),
        .memReadData        (memReadData),
        .memAccessError     (memAccessError)
    );

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ready_delay, input int resp_delay,
                              input logic [31:0] rdata, input int exp_stall, input logic exp_err,
                              input string name);
        logic [64:0] exp_req;
        logic        have_req = 1'b0;
        logic        fin = 1'b0;
        int          phase = 0;
        int          wait_req = 0;
        int          wait_resp = 0;
        int          stall_cnt;
        req_q.push_back({wr, addr & 32'hFFFF_FFFC, wdata});
        if (!wr) rd_q.push_back(exp_err ? 32'hDEADBEEF : rdata);
        exp_req = '0;
        @(negedge clk);
        memMemRead = rd;
        memMemWrite = wr;
        memAluResult = addr;
        memMemoryWriteData = wdata;
        #1;
        stall_cnt = stall ? 1 : 0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            dmemReqReady = 1'b0;
            dmemRespValid = 1'b0;
            if (!stall) begin
                fin = 1'b1;
                memMemRead = 1'b0;
                memMemWrite = 1'b0;
                if (!wr) last_rd = rd_q.pop_front();
                n_cmp++;
                if (stall_cnt !== exp_stall) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
                end
                n_cmp++;
                if (memReadData !== last_rd) begin
                    n_fail++;
                    $display("FAIL %s read_data: got %h expected %h", name, memReadData, last_rd);
                end
                n_cmp++;
                if (memAccessError !== exp_err) begin
                    n_fail++;
                    $display("FAIL %s access_error: got %b expected %b", name, memAccessError, exp_err);
                end
                n_cmp++;
                if (dmemReqValid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s valid_in_done: got %b expected 0", name, dmemReqValid);
                end
            end else begin
                stall_cnt++;
                if (phase == 0 && dmemReqValid) begin
                    if (!have_req) begin
                        exp_req = req_q.pop_front();
                        have_req = 1'b1;
                    end
                    n_cmp++;
                    if ({dmemReqWrite, dmemAddr, dmemWData} !== exp_req) begin
                        n_fail++;
                        $display("FAIL %s request: got %b/%h/%h expected %b/%h/%h", name, dmemReqWrite,
                                 dmemAddr, dmemWData, exp_req[64], exp_req[63:32], exp_req[31:0]);
                    end
                    if (wait_req == ready_delay) begin
                        dmemReqReady = 1'b1;
                        phase = wr ? 2 : 1;
                    end else begin
                        wait_req++;
                    end
                end else if (phase == 1) begin
                    if (wait_resp == resp_delay) begin
                        dmemRespValid = 1'b1;
                        dmemRData = rdata;
                        phase = 2;
                    end else begin
                        wait_resp++;
                    end
                end
            end
        end
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s completion: got no DONE expected DONE within 300 cycles", name);
            memMemRead = 1'b0;
            memMemWrite = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({stall, dmemReqValid, dmemReqWrite, memAccessError} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {stall, dmemReqValid, dmemReqWrite, memAccessError});
        end
        n_cmp++;
        if ({dmemAddr, dmemWData, memReadData} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", dmemAddr, dmemWData, memReadData);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({stall, dmemReqValid} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_hold: got %b expected 00", {stall, dmemReqValid});
            end
        end
    endtask

    task automatic test_load();
        run_access(1'b1, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'hCAFE_F00D, 3, 1'b0, "load");
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 2, 0, 32'h0, 4, 1'b0, "store");
    endtask

    task automatic test_both_strobes();
        run_access(1'b1, 1'b1, 32'h0000_0046, 32'hA5A5_5A5A, 1, 0, 32'h0, 3, 1'b0, "both");
        @(negedge clk);
        dmemRespValid = 1'b1;
        dmemRData = 32'h1111_1111;
        @(negedge clk);
        dmemRespValid = 1'b0;
        n_cmp++;
        if (memReadData !== last_rd) begin
            n_fail++;
            $display("FAIL idle_resp_ignored: got %h expected %h", memReadData, last_rd);
        end
        n_cmp++;
        if ({stall, dmemReqValid} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_resp_state: got %b expected 00", {stall, dmemReqValid});
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 32'h0000_2008, 32'h0, 1, 2, 32'h0BAD_C0DE, 6, 1'b0, "b2b_load0");
        run_access(1'b0, 1'b1, 32'h0000_200D, 32'hFEED_BEEF, 0, 0, 32'h0, 2, 1'b0, "b2b_store");
        run_access(1'b1, 1'b0, 32'h0000_200C, 32'h0, 0, 0, 32'h600D_F00D, 3, 1'b0, "b2b_load1");
    endtask

    task automatic test_reset_mid_access();
        req_q.push_back({1'b0, 32'h0000_3000, 32'h0});
        @(negedge clk);
        memMemRead = 1'b1;
        memAluResult = 32'h0000_3002;
        memMemoryWriteData = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({dmemReqValid, dmemReqWrite, dmemAddr, dmemWData} !== {1'b1, req_q.pop_front()}) begin
            n_fail++;
            $display("FAIL rst_mid_request: got %b/%b/%h expected 1/0/00003000", dmemReqValid, dmemReqWrite, dmemAddr);
        end
        dmemReqReady = 1'b1;
        @(negedge clk);
        dmemReqReady = 1'b0;
        n_cmp++;
        if ({stall, dmemReqValid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_in_resp: got %b expected 10", {stall, dmemReqValid});
        end
        rst = 1'b1;
        memMemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        n_cmp++;
        if ({stall, dmemReqValid, memReadData} !== 34'd0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got %b/%b/%h expected 0/0/0", stall, dmemReqValid, memReadData);
        end
        dmemRespValid = 1'b1;
        dmemRData = 32'h7777_7777;
        @(negedge clk);
        dmemRespValid = 1'b0;
        n_cmp++;
        if ({stall, memReadData} !== {1'b0, last_rd}) begin
            n_fail++;
            $display("FAIL rst_mid_late_resp: got %b/%h expected 0/%h", stall, memReadData, last_rd);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1'b1, 1'b0, 32'h0000_4004, 32'h0, 0, 1000, 32'h0, 5, 1'b1, "timeout");
        @(negedge clk);
        n_cmp++;
        if (memAccessError !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width: got %b expected 0", memAccessError);
        end
    endtask
`else
    task automatic test_long_wait();
        run_access(1'b1, 1'b0, 32'h0000_4004, 32'h0, 6, 5, 32'h5A5A_0F0F, 14, 1'b0, "long_wait");
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_both_strobes();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Memory-stage access controller sitting downstream of the EX/MEM pipeline barrier. It consumes the barrier's registered access fields (address, store data, read/write strobes). It runs each load or store against the data memory over a valid/ready request channel and a valid-only response channel. Until the access completes it drives the stall that holds the upstream barriers (their `dontUpdate`), then hands load data to the MEM/WB side.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+RESP before abort. Used only when `MEM_TIMEOUT_EN` is defined; range 1..255.

Ports (name, direction, width, meaning):
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `memAluResult` input 32: access byte address from the EX/MEM barrier.
- `memMemoryWriteData` input 32: store data.
- `memMemRead` input 1: load request.
- `memMemWrite` input 1: store request.
- `stall` output 1: combinational; high while an access is pending and not yet in DONE. Wired to `dontUpdate` of the IF/ID, ID/EX and EX/MEM barriers.
- `dmemReqValid` output 1: registered request valid.
- `dmemReqWrite` output 1: 1 = store, 0 = load.
- `dmemAddr` output 32: `{memAluResult[31:2],2'b00}`, registered at request launch.
- `dmemWData` output 32: store data, registered at request launch.
- `dmemReqReady` input 1: memory accepts the request this cycle.
- `dmemRespValid` input 1: load response valid.
- `dmemRData` input 32: load response data.
- `memReadData` output 32: last completed load data, held until the next load completes.
- `memAccessError` output 1: one-cycle pulse in DONE after a timeout abort.

## Operation
- Access = `memMemRead | memMemWrite`. If both strobes are high, the store wins (`dmemReqWrite=1`).
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE
  - If access is present: load `dmemAddr`/`dmemWData`/`dmemReqWrite`, set `dmemReqValid=1`, go to REQ. `stall=1` in this cycle.
  - If no access is present: stay in IDLE with `stall=0`.
- REQ
  - Hold `dmemReqValid`, `dmemAddr`, `dmemWData` and `dmemReqWrite` stable until `dmemReqReady`.
  - On handshake, clear `dmemReqValid`. A store goes to DONE (posted, no response expected). A load goes to RESP.
  - `dmemRespValid` is ignored in REQ.
- RESP: wait for `dmemRespValid`, then capture `dmemRData` into `memReadData` and go to DONE.
- DONE: `stall=0` for exactly one cycle, so the barriers advance and a new instruction arrives. Unconditional transition to IDLE.
- Back-to-back accesses are therefore separated by one DONE cycle plus one IDLE detect cycle.
- Responses arriving in IDLE or DONE are discarded; `memReadData` is unchanged.
- Reset values: state IDLE, `dmemReqValid=0`, `dmemReqWrite=0`, `dmemAddr=0`, `dmemWData=0`, `memReadData=0`, `memAccessError=0`, timeout counter 0.
- Reset mid-access abandons the transaction. The memory side tolerates the dropped request.

## Timing
- Load with zero-wait memory (ready high at REQ, response one cycle later): IDLE(stall) → REQ → RESP → DONE. That is 3 stall cycles; `memReadData` is valid from the cycle after the RESP edge, i.e. during DONE.
- Store with zero-wait memory: IDLE → REQ → DONE, 2 stall cycles.
- Each cycle `dmemReqReady` is low in REQ, or `dmemRespValid` is low in RESP, adds one stall cycle.
- `stall` is combinational from state and strobes. It has no path from `dmemReqReady`/`dmemRespValid`.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments every cycle in REQ/RESP.
  - When the counter equals `TIMEOUT_CYCLES - 1` and no handshake or response occurs in that cycle: drop `dmemReqValid`, write `memReadData=32'hDEADBEEF` (loads only), go to DONE and pulse `memAccessError`.
  - A handshake or response in that same cycle takes priority over the abort.
- `MEM_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely; `memAccessError` is tied to 0.

## Test plan
- Reset, then idle strobes: `stall=0`, `dmemReqValid=0`, `memReadData=0`, FSM stays in IDLE.
- Load, addr 0x1003, ready=1, response 0xCAFEF00D one cycle later:
  - `dmemAddr=0x1000`, `dmemReqWrite=0`.
  - Stall high for 3 cycles.
  - `memReadData=0xCAFEF00D` in DONE.
- Store, addr 0x20, data 0x12345678, ready low for 2 cycles:
  - Addr/data are held stable while ready is low.
  - Stall high for 4 cycles.
  - No RESP state is entered.
- Both strobes high: a store is issued (`dmemReqWrite=1`). A response pulse injected during IDLE leaves `memReadData` unchanged.
- Reset asserted while in RESP: next cycle the FSM is in IDLE with `dmemReqValid=0`, and a late response is ignored.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, load with response never arriving:
  - Abort after 4 cycles in REQ/RESP.
  - `memReadData=0xDEADBEEF`, `memAccessError` pulses 1 cycle.
  - `stall` drops in DONE.
